ntt_input_loader: RTL and testbench
===================================

NTT_INPUT_LOADER -- requirements
Module: ntt_input_loader

Interface
REQ-001 SHALL have parameter W, default 32, coefficient word width.
REQ-002 SHALL have parameter N, default 8, coefficients per frame (power of two).
REQ-003 SHALL have parameter Q, default 7681, NTT modulus.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream coefficient present.
REQ-007 SHALL have port in_ready  output  1  loader can accept a coefficient.
REQ-008 SHALL have port in_data  input  W  raw coefficient, natural order.
REQ-009 SHALL have port core_ready  input  1  NTT core idle and able to take a frame.
REQ-010 SHALL have port out_valid  output  1  out_data holds a frame coefficient.
REQ-011 SHALL have port out_data  output  W  reduced coefficient to the NTT core (its incoming_data).
REQ-012 SHALL have port out_first  output  1  first word of a frame.
REQ-013 SHALL have port out_last  output  1  last word of a frame.
REQ-014 SHALL have port range_err  output  1  sticky: an input at or above 2Q was seen.

Function
REQ-015 SHALL accept a word on any cycle where in_valid and in_ready are both 1.
REQ-016 SHALL reduce each accepted word before storing it: value < Q is stored as-is; Q <= value < 2Q is stored as value-Q; value >= 2Q is stored as 0 and sets range_err.
REQ-017 SHALL store words in two N-word banks (ping-pong), filling the write bank at indices 0..N-1 in acceptance order.
REQ-018 SHALL mark the write bank full on the cycle after its Nth word is accepted, then switch writing to the other bank.
REQ-019 SHALL drive in_ready = 0 exactly when both banks are full, and 1 otherwise.
REQ-020 SHALL implement a read FSM with states IDLE and STREAM.
REQ-021 SHALL move IDLE->STREAM on a cycle where the read bank is full and core_ready = 1; core_ready is ignored outside IDLE.
REQ-022 SHALL, in STREAM, emit N words on N consecutive cycles with out_valid = 1, starting the cycle after the transition, with no backpressure.
REQ-023 SHALL emit words in bit-reversed index order; for N=8 the order is 0,4,2,6,1,5,3,7.
REQ-024 SHALL assert out_first with the first word and out_last with the Nth word, each for one cycle only.
REQ-025 SHALL, on the out_last cycle, clear the read bank's full flag, swap to the other bank, and return to IDLE.
REQ-026 SHALL allow the read bank to become writable on the cycle after out_last.
REQ-027 SHALL process a write-bank fill and a read-bank release in the same cycle independently, with no lost or duplicated word.
REQ-028 SHALL start back-to-back frames with one IDLE cycle between out_last and the next out_first.
REQ-029 SHALL drive out_data = 0 and out_first = out_last = 0 whenever out_valid = 0.
REQ-030 SHALL have a minimum latency of N+2 cycles from acceptance of word 0 to out_first, with core_ready held at 1.

Reset
REQ-031 SHALL, when rst = 0 at a clock edge, clear both full flags, both counters and both bank selects, set the FSM to IDLE, and set out_valid = out_first = out_last = range_err = 0, out_data = 0 and in_ready = 1.
REQ-032 SHALL discard any partial frame or frame in progress when reset is asserted mid-operation; bank contents need not be cleared.

Verification
REQ-033 Basic frame: core_ready = 1; inputs 5569,3457,1345,6914,4802,2690,578,6147 -> out_data 5569,4802,1345,578,3457,2690,6914,6147, with out_first on 5569, out_last on 6147 and range_err = 0.
REQ-034 Reduction: input 7686 at index 0 -> out_data 5 as the first word; input 20000 -> stored 0 and range_err = 1 until reset.
REQ-035 Backpressure: core_ready = 0; 16 words offered -> in_ready = 0 from the cycle after the 16th acceptance, the 17th is not accepted; core_ready = 1 -> two frames out in order with one IDLE cycle between them.
REQ-036 Simultaneous fill/release: the second bank's 8th word is accepted in the same cycle as the first bank's out_last -> no stall; all 16 words are emitted correctly.
REQ-037 Reset mid-stream: rst = 0 during the 4th output word -> the next cycle has out_valid = 0 and in_ready = 1; a new 8-word frame is emitted cleanly with no stale words.
REQ-038 Continuous streaming: 4 frames with in_valid held at 1 and core_ready held at 1 -> all 32 words are emitted bit-reversed per frame and the out_first count equals 4.

Source files
------------

// File: rtl/ntt_input_loader.sv
// Ping-pong input buffer ahead of an NTT core: reduces raw coefficients mod Q,
// fills one N-word bank while the other is streamed out in bit-reversed order.
module ntt_input_loader #(
    parameter int W = 32,
    parameter int N = 8,
    parameter int Q = 7681
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         core_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_first,
    output logic         out_last,
    output logic         range_err
);
    localparam int W1 = W + 1;
    localparam int LG = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  Q1   = W'(Q);
    localparam logic [W:0]    Q2   = W1'(2 * Q);
    localparam logic [LG-1:0] LAST = LG'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state;
    logic [W-1:0]  mem [2][N];
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [LG-1:0] wr_cnt;
    logic [LG-1:0] rd_cnt;
    logic          accept;
    logic [W-1:0]  red_data;
    logic          red_oor;

    function automatic logic [LG-1:0] bit_rev(input logic [LG-1:0] idx);
        logic [LG-1:0] res;
        for (int b = 0; b < LG; b++) res[b] = idx[LG-1-b];
        return res;
    endfunction

    assign in_ready = !(full[0] && full[1]);
    assign accept   = in_valid && in_ready;

    // Single conditional subtract covers [0, 2Q); anything larger is flagged.
    always_comb begin
        red_data = in_data;
        red_oor  = 1'b0;
        if ({1'b0, in_data} >= Q2) begin
            red_data = '0;
            red_oor  = 1'b1;
        end else if (in_data >= Q1) begin
            red_data = in_data - Q1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_bank][wr_cnt] <= red_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (accept) begin
                if (red_oor) range_err <= 1'b1;
                if (wr_cnt == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_cnt        <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            // rd_bank already points at the next bank while the last word is out,
            // so the bank being released is the other one.
            if (out_last) full[~rd_bank] <= 1'b0;

            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;

            case (state)
                IDLE: begin
                    if (full[rd_bank] && core_ready) begin
                        state  <= STREAM;
                        rd_cnt <= '0;
                    end
                end
                STREAM: begin
                    out_valid <= 1'b1;
                    out_data  <= mem[rd_bank][bit_rev(rd_cnt)];
                    out_first <= (rd_cnt == '0);
                    out_last  <= (rd_cnt == LAST);
                    rd_cnt    <= rd_cnt + 1'b1;
                    // Leave STREAM as the last read issues so the next frame can
                    // be picked up during the out_last cycle.
                    if (rd_cnt == LAST) begin
                        state   <= IDLE;
                        rd_bank <= ~rd_bank;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_input_loader.sv
// Directed bench for ntt_input_loader: basic frame, reduction, backpressure,
// simultaneous fill/release, mid-stream reset and continuous streaming.
module tb_ntt_input_loader;
    localparam int W = 32;
    localparam int N = 8;
    localparam int Q = 7681;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         core_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_first;
    logic         out_last;
    logic         range_err;

    ntt_input_loader #(.W(W), .N(N), .Q(Q)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .core_ready(core_ready), .out_valid(out_valid),
        .out_data(out_data), .out_first(out_first), .out_last(out_last),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        f;
        logic        l;
        int          c;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   bad_idle = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always @(posedge clk) cyc <= cyc + 1;

    // Output recorder: every valid word with its cycle; idle-cycle garbage is counted.
    always @(negedge clk) begin
        if (out_valid) q.push_back('{out_data, out_first, out_last, cyc});
        else if (out_data != '0 || out_first || out_last) bad_idle++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic [31:0] v, output int ac);
        in_valid = 1'b1;
        in_data  = v;
        ac = -1;
        for (int t = 0; t < 300 && ac < 0; t++) begin
            if (in_ready) ac = cyc;
            step();
        end
        if (ac < 0) chk("send_timeout_in_ready", in_ready, 1);
    endtask

    task automatic wait_q(input int n, input int bound);
        for (int t = 0; t < bound && q.size() < n; t++) step();
        chk("out_word_count", q.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        q.delete();
    endtask

    initial begin
        int acc[32];
        logic [31:0] e1[8];
        logic [31:0] v1[8];
        logic [31:0] v2[8];
        logic [31:0] e2[8];
        logic [7:0]  fv;
        logic [7:0]  lv;
        int nf;
        int nl;

        v1 = '{5569, 3457, 1345, 6914, 4802, 2690, 578, 6147};
        e1 = '{5569, 4802, 1345, 578, 3457, 2690, 6914, 6147};
        v2 = '{7686, 7680, 7681, 15361, 15362, 20000, 3, 4};
        e2 = '{5, 0, 0, 3, 7680, 0, 7680, 4};

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        step();
        q.delete();

        // Basic frame
        core_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(v1[i], acc[i]);
        in_valid = 1'b0;
        wait_q(8, 40);
        for (int i = 0; i < 8; i++) begin
            chk("basic_data", q[i].d, e1[i]);
            fv[i] = q[i].f;
            lv[i] = q[i].l;
        end
        chk("basic_first", fv, 8'h01);
        chk("basic_last", lv, 8'h80);
        chk("basic_latency", q[0].c - acc[0], 10);
        chk("basic_burst", q[7].c - q[0].c, 7);
        chk("basic_range_err", range_err, 0);

        // Reduction boundaries (second bank, no reset in between)
        q.delete();
        for (int i = 0; i < 8; i++) begin
            send(v2[i], acc[i]);
            if (i == 3) chk("err_below_2q", range_err, 0);
            if (i == 4) chk("err_at_2q", range_err, 1);
        end
        in_valid = 1'b0;
        wait_q(8, 40);
        for (int i = 0; i < 8; i++) chk("reduce_data", q[i].d, e2[i]);
        chk("err_sticky", range_err, 1);
        do_reset();
        chk("err_cleared_by_reset", range_err, 0);

        // Backpressure: both banks fill while the core is busy
        core_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(100 + i, acc[i]);
        chk("bp_in_ready_low", in_ready, 0);
        in_data = 999;
        step();
        step();
        step();
        chk("bp_still_low", in_ready, 0);
        chk("bp_no_output", q.size(), 0);
        in_valid = 1'b0;
        core_ready = 1'b1;
        wait_q(16, 80);
        for (int j = 0; j < 16; j++) chk("bp_data", q[j].d, 100 + (j / 8) * 8 + br[j % 8]);
        chk("bp_gap", q[8].c - q[7].c, 2);
        chk("bp_first2", q[8].f, 1);
        chk("bp_last1", q[7].l, 1);

        // Simultaneous fill of bank B and release of bank A
        do_reset();
        core_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(200 + i, acc[i]);
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 8; i++) send(300 + i, acc[8 + i]);
        in_valid = 1'b0;
        wait_q(16, 80);
        chk("simul_no_stall", acc[15] - acc[8], 7);
        chk("simul_align", acc[15], q[7].c);
        for (int j = 0; j < 16; j++) chk("simul_data", q[j].d, 200 + (j / 8) * 100 + br[j % 8]);

        // Reset during the 4th output word
        do_reset();
        core_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(600 + i, acc[i]);
        in_valid = 1'b0;
        for (int t = 0; t < 40 && !(q.size() == 3 && out_valid); t++) step();
        chk("mid_4th_word", out_data, 600 + 6);
        rst = 1'b0;
        step();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) send(400 + i, acc[i]);
        in_valid = 1'b0;
        wait_q(8, 40);
        for (int i = 0; i < 8; i++) chk("mid_new_data", q[i].d, 400 + br[i]);
        for (int t = 0; t < 6; t++) step();
        chk("mid_no_stale", q.size(), 8);

        // Continuous streaming, in_valid and core_ready held high
        do_reset();
        core_ready = 1'b1;
        for (int i = 0; i < 32; i++) send(500 + i, acc[i]);
        in_valid = 1'b0;
        wait_q(32, 200);
        nf = 0;
        nl = 0;
        for (int j = 0; j < 32; j++) begin
            chk("cont_data", q[j].d, 500 + (j / 8) * 8 + br[j % 8]);
            nf += int'(q[j].f);
            nl += int'(q[j].l);
        end
        chk("cont_first_count", nf, 4);
        chk("cont_last_count", nl, 4);
        chk("idle_outputs_zero", bad_idle, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
